// File: rtl/digit_serial_adder.sv
// ---------------------------------------------------------------------------
// digit_serial_adder
//
// Multi-cycle add/subtract unit. A WIDTH-bit operand pair is added DIGIT bits
// per clock, least significant digit first, with the carry between digits
// held in a register. Wide adds cost one DIGIT-wide adder instead of a full
// WIDTH-wide one, at the price of N = WIDTH/DIGIT clocks per operation.
//
// Parameters
//   WIDTH      operand/result width, must be a multiple of DIGIT
//   DIGIT      bits processed per clock (1..WIDTH)
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   in_valid   operands/mode/cin presented by upstream
//   in_ready   high only while idle; an operation is taken on in_valid&in_ready
//   a, b       operands
//   cin        carry-in (mode=0) or borrow-in (mode=1)
//   mode       0: a+b+cin, 1: a-b-cin
//   out_valid  result registers hold a completed result
//   out_ready  downstream accepts the result
//   sum        result modulo 2^WIDTH
//   cout       final carry; in subtract mode 1 means "no borrow"
//   ovf        two's-complement signed overflow of the result
// ---------------------------------------------------------------------------
module digit_serial_adder #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_eff;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic [DIGIT-1:0] a_dig;
  logic [DIGIT-1:0] b_dig;
  logic [DIGIT-1:0] dig_sum;
  logic             dig_carry;
  logic             last_digit;

  // Only an idle unit takes new work; anything offered while busy is dropped
  // by upstream's own handshake rules, never queued here.
  assign in_ready = (state == IDLE);

  // Select the current digit of each captured operand. A compare-per-digit
  // mux keeps every slice index a constant.
  always_comb begin
    a_dig = '0;
    b_dig = '0;
    for (int i = 0; i < N; i++) begin
      if (cnt == CW'(i)) begin
        a_dig = a_reg[i*DIGIT +: DIGIT];
        b_dig = b_eff[i*DIGIT +: DIGIT];
      end
    end
  end

  // The single DIGIT-wide adder shared by every digit cycle. Subtraction is
  // folded in at capture time (inverted b, inverted borrow as carry), so the
  // adder itself never needs to know the mode.
  assign {dig_carry, dig_sum} = {1'b0, a_dig} + {1'b0, b_dig} + {{DIGIT{1'b0}}, carry};
  assign last_digit           = (cnt == CW'(N - 1));

  // Control and datapath registers. DONE spends one cycle with out_valid low
  // after the last digit so that the result is advertised a full cycle after
  // the final carry and overflow have been registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      a_reg     <= '0;
      b_eff     <= '0;
      carry     <= 1'b0;
      cnt       <= '0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg <= a;
            b_eff <= mode ? ~b : b;
            carry <= mode ^ cin;
            cnt   <= '0;
            sum   <= '0;
            state <= RUN;
          end
        end

        RUN: begin
          for (int i = 0; i < N; i++) begin
            if (cnt == CW'(i)) begin
              sum[i*DIGIT +: DIGIT] <= dig_sum;
            end
          end
          carry <= dig_carry;
          if (last_digit) begin
            // The top digit being written now holds the result's sign bit.
            cnt   <= '0;
            cout  <= dig_carry;
            ovf   <= (a_reg[WIDTH-1] == b_eff[WIDTH-1]) &&
                     (dig_sum[DIGIT-1] != a_reg[WIDTH-1]);
            state <= DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        DONE: begin
          if (!out_valid) begin
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
